// File: rtl/mem_1rw_pkg.sv
// mem_1rw_pkg: shared configuration and response entry type for the mem_1rw front-end
package mem_1rw_pkg;
  localparam int DEPTH = 48;
  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 64;
  localparam int RESP_DEPTH = 2;
  localparam int ERR_CNT_WIDTH = 8;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic err;
  } resp_entry_t;
endpackage

// File: rtl/mem_1rw_resp_fifo.sv
// mem_1rw_resp_fifo: small synchronous FIFO of read responses
module mem_1rw_resp_fifo
  import mem_1rw_pkg::*;
#(
  parameter int N = RESP_DEPTH,
  localparam int PW = N > 1 ? $clog2(N) : 1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  resp_entry_t din,
  input  logic pop,
  output resp_entry_t dout,
  output logic [CW-1:0] count,
  output logic full,
  output logic empty
);
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(N);
  resp_entry_t mem [N];
  logic [PW-1:0] wp, rp;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp == LAST ? '0 : wp + 1'b1;
      end
      if (pop) rp <= rp == LAST ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout = mem[rp];
  assign full = count == FULL_CNT;
  assign empty = count == '0;
endmodule

// File: rtl/mem_1rw_req_ctrl.sv
// mem_1rw_req_ctrl: valid/ready request front-end for mem_1rw with ordered, credit-protected read responses
module mem_1rw_req_ctrl
  import mem_1rw_pkg::*;
#(
  parameter int DEPTH = mem_1rw_pkg::DEPTH,
  parameter int ADDR_WIDTH = mem_1rw_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = mem_1rw_pkg::DATA_WIDTH,
  parameter int RESP_DEPTH = mem_1rw_pkg::RESP_DEPTH,
  parameter int ERR_CNT_WIDTH = mem_1rw_pkg::ERR_CNT_WIDTH
) (
  input  logic clock,
  input  logic reset,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic resp_valid,
  input  logic resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic resp_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic RW0_clk,
  output logic RW0_en,
  output logic RW0_wmode,
  output logic [ADDR_WIDTH-1:0] RW0_addr,
  output logic [DATA_WIDTH-1:0] RW0_wdata,
  input  logic [DATA_WIDTH-1:0] RW0_rdata
);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CW:0] CREDITS = (CW + 1)'(RESP_DEPTH);
  logic fire, rd_fire, in_range, pop, rd_pending, rd_err, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  resp_entry_t head, push_entry;
  assign in_range = {1'b0, req_addr} < LIMIT;
  assign pop = resp_valid & resp_ready;
  // A slot freed by this cycle's pop is reusable at once, keeping one request per cycle with two credits
  assign req_ready = !reset & ((({1'b0, fifo_count} + (CW + 1)'(rd_pending)) < CREDITS) | pop);
  assign fire = req_valid & req_ready;
  assign rd_fire = fire & !req_write;
  assign RW0_clk = clock;
  assign RW0_en = fire & in_range;
  assign RW0_wmode = req_write;
  assign RW0_addr = req_addr;
  assign RW0_wdata = req_wdata;
  assign push_entry = rd_err ? resp_entry_t'{rdata: '0, err: 1'b1} : resp_entry_t'{rdata: RW0_rdata, err: 1'b0};
  assign resp_valid = !reset & !fifo_empty;
  assign resp_rdata = reset ? '0 : head.rdata;
  assign resp_err = !reset & head.err;
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pending <= 1'b0;
      rd_err <= 1'b0;
      err_count <= '0;
    end else begin
      rd_pending <= rd_fire;
      if (rd_fire) rd_err <= !in_range;
      if (fire & !in_range & ~&err_count) err_count <= err_count + 1'b1;
    end
  end
  mem_1rw_resp_fifo #(.N(RESP_DEPTH)) u_fifo (
    .clk(clock),
    .rst(reset),
    .push(rd_pending),
    .din(push_entry),
    .pop(pop),
    .dout(head),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  no_overflow: assert property (@(posedge clock) disable iff (reset) !(fifo_full && rd_pending && !pop));
endmodule

// File: tb/tb_mem_1rw_req_ctrl.sv
// tb_mem_1rw_req_ctrl: randomized and directed bench with an in-bench RAM and response-queue model
module tb_mem_1rw_req_ctrl;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_write = 0, resp_ready = 0;
  logic [5:0] req_addr = 0;
  logic [63:0] req_wdata = 0;
  logic req_ready, resp_valid, resp_err, RW0_clk, RW0_en, RW0_wmode;
  logic [63:0] resp_rdata, RW0_wdata;
  logic [63:0] RW0_rdata = 0;
  logic [7:0] err_count;
  logic [5:0] RW0_addr;
  always #5 clk = ~clk;

  mem_1rw_req_ctrl dut (
    .clock(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .err_count(err_count), .RW0_clk(RW0_clk),
    .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr), .RW0_wdata(RW0_wdata),
    .RW0_rdata(RW0_rdata)
  );

  logic [63:0] ram [64];
  always @(posedge clk) if (RW0_en) begin
    if (RW0_wmode) ram[RW0_addr] <= RW0_wdata;
    else RW0_rdata <= ram[RW0_addr];
  end

  int total = 0, bad = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  // Model: every accepted read owes one response, due two cycles after acceptance, in order
  typedef struct {logic [63:0] d; logic e; int c;} exp_t;
  exp_t q[$];
  exp_t ne;
  logic [63:0] sh [64];
  int cyc = 0, errc = 0, resp_cnt = 0, fire_cnt = 0, stall_cnt = 0, en_cnt = 0;
  logic [63:0] last_d = 0, prev_d = 0;
  logic last_e = 0;
  logic m_valid, m_pop, m_ready, m_fire, m_inr;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", resp_valid, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_err", resp_err, 0);
      chk("rst_en", RW0_en, 0);
      q.delete();
      errc = 0;
    end else begin
      m_valid = q.size() > 0 && q[0].c + 2 <= cyc;
      m_pop = m_valid && resp_ready;
      m_ready = (q.size() - int'(m_pop)) < 2;
      m_fire = req_valid && m_ready;
      m_inr = req_addr < 6'd48;
      chk("req_ready", req_ready, m_ready);
      chk("resp_valid", resp_valid, m_valid);
      if (m_valid) begin
        chk("resp_rdata", resp_rdata, q[0].d);
        chk("resp_err", resp_err, q[0].e);
      end
      chk("rw0_en", RW0_en, m_fire && m_inr);
      chk("rw0_wmode", RW0_wmode, req_write);
      chk("rw0_addr", RW0_addr, req_addr);
      chk("rw0_wdata", RW0_wdata, req_wdata);
      chk("err_count", err_count, errc);
      if (RW0_en) en_cnt++;
      if (req_valid && !m_ready) stall_cnt++;
      if (m_pop) begin
        prev_d = last_d;
        last_d = resp_rdata;
        last_e = resp_err;
        resp_cnt++;
        void'(q.pop_front());
      end
      if (m_fire) begin
        fire_cnt++;
        if (!m_inr) errc = errc == 255 ? 255 : errc + 1;
        if (req_write) begin
          if (m_inr) sh[req_addr] = req_wdata;
        end else begin
          ne.d = m_inr ? sh[req_addr] : 64'd0;
          ne.e = !m_inr;
          ne.c = cyc;
          q.push_back(ne);
        end
      end
    end
    cyc++;
  end

  task automatic send(input logic w, input logic [5:0] a, input logic [63:0] d);
    logic acc = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_ready) begin acc = 1; break; end
    end
    @(posedge clk); #1;
    req_valid = 0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (q.size() == 0) return;
    end
    chk("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  int f0, r0, s0, e0;
  initial begin
    for (int i = 0; i < 64; i++) begin ram[i] = 0; sh[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    resp_ready = 1;
    e0 = en_cnt;
    send(1, 5, 64'hDEADBEEF_00000005);
    send(0, 5, 0);
    drain();
    chk("t1_en_pulses", en_cnt - e0, 2);
    chk("t1_data", last_d, 64'hDEADBEEF_00000005);
    chk("t1_err", last_e, 0);

    for (int i = 0; i < 8; i++) send(1, 6'(i), 64'(i));
    r0 = resp_cnt; s0 = stall_cnt;
    for (int i = 0; i < 8; i++) send(0, 6'(i), 0);
    drain();
    chk("t2_count", resp_cnt - r0, 8);
    chk("t2_stalls", stall_cnt - s0, 0);
    chk("t2_last", last_d, 7);

    resp_ready = 0;
    f0 = fire_cnt; r0 = resp_cnt;
    req_valid = 1; req_write = 0; req_addr = 6;
    repeat (6) @(posedge clk);
    #1;
    chk("t3_accepted", fire_cnt - f0, 2);
    chk("t3_no_resp", resp_cnt - r0, 0);
    resp_ready = 1;
    for (int t = 0; t < 50; t++) begin
      if (fire_cnt - f0 >= 4) break;
      @(posedge clk); #1;
    end
    req_valid = 0;
    drain();
    chk("t3_total", resp_cnt - r0, 4);
    chk("t3_data", last_d, 6);

    do_reset();
    send(1, 47, 64'hA5A5);
    send(0, 47, 0);
    send(0, 48, 0);
    send(1, 63, 64'h1234);
    drain();
    chk("t4_err_count", err_count, 2);
    chk("t4_47_data", prev_d, 64'hA5A5);
    chk("t4_48_data", last_d, 0);
    chk("t4_48_err", last_e, 1);
    chk("t4_drop", ram[63], 0);

    for (int i = 0; i < 300; i++) send(1, 6'(48 + i % 16), 64'(i));
    chk("t5_saturate", err_count, 255);

    do_reset();
    r0 = resp_cnt;
    send(0, 1, 0);
    send(0, 2, 0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_none", resp_cnt - r0, 0);
    send(0, 3, 0);
    drain();
    chk("t6_count", resp_cnt - r0, 1);
    chk("t6_data", last_d, 3);

    for (int i = 0; i < 600; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_write = $urandom_range(0, 9) < 3;
      req_addr = 6'($urandom_range(0, 63));
      req_wdata = {$urandom, $urandom};
      resp_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    req_valid = 0; resp_ready = 1;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
